pid_plant_model: RTL and testbench

- Discrete-time first-order-plus-dead-time plant model.
- Closes the loop around the PID controller: consumes the controller output uk0 and produces the measured value y fed back to the controller's y input.
- Updates once per sample period, set by an internal clock divider. Contains an input clamp, a dead-time ring buffer, a gain multiply and a first-order lag accumulator.
- Used for closed-loop simulation and on-chip self-test of the PID datapath.

---
 rtl/pid_plant_model_if.sv | 21 ++
 rtl/pid_plant_model.sv | 131 +++++++++++++
 tb/tb_pid_plant_model.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/pid_plant_model_if.sv
// Plant-side bundle: controller output and plant coefficients in, plant measurement out.
interface pid_plant_model_if;
  logic               en;
  logic signed [31:0] uk0;
  logic        [15:0] gain;
  logic        [3:0]  shift;
  logic        [3:0]  delay;
  logic signed [31:0] y;
  logic               y_valid;
  logic               sat;

  modport master (
    output en, uk0, gain, shift, delay,
    input  y, y_valid, sat
  );

  modport slave (
    input  en, uk0, gain, shift, delay,
    output y, y_valid, sat
  );
endinterface

// File: rtl/pid_plant_model.sv
// First-order-plus-dead-time plant: input clamp, dead-time ring buffer, Q8.8 gain,
// and a 2^-shift lag accumulator, updated once every DIV clocks.
module pid_plant_model #(
  parameter int                 DIV   = 8,
  parameter logic signed [31:0] U_MAX = 32'sd100000,
  parameter logic signed [31:0] U_MIN = -32'sd100000,
  parameter int                 DEPTH = 16
) (
  input logic              clk,
  input logic              rst_n,
  pid_plant_model_if.slave bus
);
  localparam int DATA_W = 32;
  localparam int COEF_W = 16;
  localparam int MUL_W  = DATA_W + COEF_W + 1;
  localparam int PROD_W = 48;
  localparam int DIFF_W = 50;
  localparam int AW     = $clog2(DEPTH);
  localparam int CW     = $clog2(DIV);

  localparam logic signed [DIFF_W-1:0] Y_MAX = {{(DIFF_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [DIFF_W-1:0] Y_MIN = {{(DIFF_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MUL, ACC} state_t;

  function automatic logic signed [DATA_W-1:0] clamp_in(input logic signed [DATA_W-1:0] u);
    if (u > U_MAX)      return U_MAX;
    else if (u < U_MIN) return U_MIN;
    else                return u;
  endfunction

  function automatic logic is_clamped(input logic signed [DATA_W-1:0] u);
    return (u > U_MAX) || (u < U_MIN);
  endfunction

  function automatic logic signed [DATA_W-1:0] sat_out(input logic signed [DIFF_W-1:0] v);
    if (v > Y_MAX)      return {1'b0, {(DATA_W-1){1'b1}}};
    else if (v < Y_MIN) return {1'b1, {(DATA_W-1){1'b0}}};
    else                return v[DATA_W-1:0];
  endfunction

  state_t state, state_n;

  // ---- stage p0: sample timer ----
  logic [CW-1:0] cnt_p0;
  logic          tick_p0;

  assign tick_p0 = bus.en && (cnt_p0 == CW'(DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       cnt_p0 <= '0;
    else if (!bus.en) cnt_p0 <= '0;
    else if (tick_p0) cnt_p0 <= '0;
    else              cnt_p0 <= cnt_p0 + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (tick_p0) state_n = MUL;
      MUL:     state_n = ACC;
      ACC:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // ---- stage p1: clamp, dead-time buffer, gain multiply ----
  logic signed [DATA_W-1:0] dly_mem [DEPTH];
  logic        [AW-1:0]     wr_ptr;
  logic        [AW-1:0]     rd_idx_p1;
  logic signed [DATA_W-1:0] u_sat_p1;
  logic signed [DATA_W-1:0] u_d_p1;
  logic signed [MUL_W-1:0]  mul_a_p1, mul_b_p1, mul_full_p1;
  logic signed [PROD_W-1:0] prod_n_p1;
  logic signed [PROD_W-1:0] prod_p1;
  logic                     sat_p1;

  assign rd_idx_p1 = wr_ptr - AW'(bus.delay);
  assign u_sat_p1  = clamp_in(bus.uk0);
  // A zero delay must see this sample's input, which is not yet in the buffer.
  assign u_d_p1    = (bus.delay == '0) ? u_sat_p1 : dly_mem[rd_idx_p1];

  assign mul_a_p1    = MUL_W'(u_d_p1);
  assign mul_b_p1    = $signed({{(MUL_W-COEF_W){1'b0}}, bus.gain});
  assign mul_full_p1 = mul_a_p1 * mul_b_p1;
  assign prod_n_p1   = PROD_W'(mul_full_p1 >>> 8);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      sat_p1 <= 1'b0;
      for (int i = 0; i < DEPTH; i++) dly_mem[i] <= '0;
    end else if (state == MUL) begin
      dly_mem[wr_ptr] <= u_sat_p1;
      wr_ptr          <= wr_ptr + AW'(1);
      sat_p1          <= is_clamped(bus.uk0);
    end
  end

  always_ff @(posedge clk) begin
    if (state == MUL) prod_p1 <= prod_n_p1;
  end

  // ---- stage p2: first-order lag accumulate and output saturation ----
  logic signed [DIFF_W-1:0] diff_p2;
  logic signed [DIFF_W-1:0] sum_p2;
  logic signed [DATA_W-1:0] y_p2;
  logic                     vld_p2;

  assign diff_p2 = DIFF_W'(prod_p1) - DIFF_W'(y_p2);
  assign sum_p2  = DIFF_W'(y_p2) + (diff_p2 >>> bus.shift);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_p2   <= '0;
      vld_p2 <= 1'b0;
    end else begin
      vld_p2 <= (state == ACC);
      if (state == ACC) y_p2 <= sat_out(sum_p2);
    end
  end

  assign bus.y       = y_p2;
  assign bus.y_valid = vld_p2;
  assign bus.sat     = sat_p1;
endmodule

// File: tb/tb_pid_plant_model.sv
// Directed bench for pid_plant_model with DIV=4: table of single-sample vectors plus
// hand-written dead-time, enable-drop and mid-update reset sequences.
module tb_pid_plant_model;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  pid_plant_model_if bus();

  pid_plant_model #(.DIV(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int uk0;
    int gain;
    int shift;
    int exp_y;
    int exp_sat;
  } vec_t;

  localparam int NV = 20;
  vec_t tbl [NV];

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_pulse(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.y_valid === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL y_valid_timeout: got no pulse expected pulse within 40 cycles");
    end
  endtask

  task automatic apply(input vec_t v);
    bus.uk0   = v.uk0;
    bus.gain  = 16'(v.gain);
    bus.shift = 4'(v.shift);
  endtask

  initial begin
    bit seen;
    int last_cyc;
    int npulse;
    int exp_dly [6];

    tbl[0]  = '{5000,    256,   0, 5000,     0};
    tbl[1]  = '{200000,  256,   0, 100000,   1};
    tbl[2]  = '{-300000, 256,   0, -100000,  1};
    tbl[3]  = '{100000,  256,   0, 100000,   0};
    tbl[4]  = '{100001,  256,   0, 100000,   1};
    tbl[5]  = '{-100000, 256,   0, -100000,  0};
    tbl[6]  = '{-1000,   512,   0, -2000,    0};
    tbl[7]  = '{100000,  65535, 0, 25599609, 0};
    tbl[8]  = '{0,       256,   0, 0,        0};
    tbl[9]  = '{1000,    256,   1, 500,      0};
    tbl[10] = '{1000,    256,   1, 750,      0};
    tbl[11] = '{1000,    256,   1, 875,      0};
    tbl[12] = '{1000,    256,   1, 937,      0};
    tbl[13] = '{1000,    256,   1, 968,      0};
    tbl[14] = '{0,       256,   0, 0,        0};
    tbl[15] = '{-1000,   256,   1, -500,     0};
    tbl[16] = '{-1000,   256,   1, -750,     0};
    tbl[17] = '{-1000,   256,   1, -875,     0};
    tbl[18] = '{-1000,   256,   1, -938,     0};
    tbl[19] = '{1000,    128,   2, -579,     0};

    exp_dly = '{0, 0, 0, 500, 750, 875};

    // Table run: delay 0, one sample per vector.
    bus.en    = 1'b1;
    bus.delay = 4'd0;
    apply(tbl[0]);
    repeat (3) @(negedge clk);
    chk("reset_y",       64'(bus.y),       64'(0));
    chk("reset_y_valid", 64'(bus.y_valid), 64'(0));
    chk("reset_sat",     64'(bus.sat),     64'(0));
    rst_n    = 1'b1;
    last_cyc = cyc;

    for (int k = 0; k < NV; k++) begin
      wait_pulse(seen);
      if (seen) begin
        if (k == 0) chk("first_latency", 64'(cyc - last_cyc), 64'(6));
        else        chk($sformatf("period_%0d", k), 64'(cyc - last_cyc), 64'(4));
        last_cyc = cyc;
        chk($sformatf("vec%0d_y", k),   64'(bus.y),   64'(tbl[k].exp_y));
        chk($sformatf("vec%0d_sat", k), 64'(bus.sat), 64'(tbl[k].exp_sat));
        @(negedge clk);
        chk($sformatf("vec%0d_pulse_width", k), 64'(bus.y_valid), 64'(0));
        if (k + 1 < NV) apply(tbl[k + 1]);
      end
    end

    // Dead time of 3 samples from reset.
    @(negedge clk);
    rst_n     = 1'b0;
    bus.uk0   = 1000;
    bus.gain  = 16'd256;
    bus.shift = 4'd1;
    bus.delay = 4'd3;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      wait_pulse(seen);
      if (seen) chk($sformatf("delay3_y%0d", k), 64'(bus.y), 64'(exp_dly[k]));
    end

    // Drop en while the next update is in MUL: it still completes, then no more pulses.
    @(negedge clk);
    @(negedge clk);
    bus.en = 1'b0;
    wait_pulse(seen);
    if (seen) chk("en_drop_last_y", 64'(bus.y), 64'(937));
    npulse = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.y_valid === 1'b1) npulse++;
    end
    chk("en_off_pulses", 64'(npulse), 64'(0));

    // Re-enable and hit reset while the update sits in ACC.
    bus.uk0   = 5000;
    bus.gain  = 16'd256;
    bus.shift = 4'd0;
    bus.delay = 4'd2;
    bus.en    = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("pre_reset_y", 64'(bus.y), 64'(937));
    rst_n = 1'b0;
    #1;
    chk("acc_reset_y",       64'(bus.y),       64'(0));
    chk("acc_reset_y_valid", 64'(bus.y_valid), 64'(0));
    chk("acc_reset_sat",     64'(bus.sat),     64'(0));
    @(negedge clk);
    @(posedge clk);
    #1;
    chk("acc_reset_no_pulse", 64'(bus.y_valid), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_pulse(seen);
      if (seen) chk($sformatf("post_reset_y%0d", k), 64'(bus.y), (k < 2) ? 64'(0) : 64'(5000));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
